// File: rtl/spi3w_pkg.sv
// Shared types and constants for the 3-wire SPI configuration responder.
package spi3w_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInstr,
    StWdata,
    StRdata,
    StDone
  } state_e;

  // Instruction lengths in bits
  localparam int unsigned IL_2BYTE = 16;
  localparam int unsigned IL_1BYTE = 8;

  // Position of the R/W flag inside the instruction word
  localparam int unsigned RW_BIT_2BYTE = 15;
  localparam int unsigned RW_BIT_1BYTE = 7;

  // Address field widths
  localparam int unsigned ADDR_W       = 13;
  localparam int unsigned ADDR_W_1BYTE = 7;

  // Bit counter width, large enough to count a 16-bit instruction
  localparam int unsigned CNT_W = 5;

  // Extract the register address from a completed instruction word.
  function automatic logic [ADDR_W-1:0] instr_addr(input logic [15:0] instr,
                                                   input bit          two_byte);
    if (two_byte) begin
      return instr[ADDR_W-1:0];
    end
    return ADDR_W'(instr[ADDR_W_1BYTE-1:0]);
  endfunction

endpackage

// File: rtl/spi3w_pin_sync.sv
// Synchronizes the SPI pins into clk_50m and produces edge pulses.
module spi3w_pin_sync (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic sdio_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic sdio_s
);

  // [0] first sync stage, [1] second sync stage, [2] history
  logic [2:0] cs_q;
  logic [2:0] sclk_q;
  // sdio needs no history: it is only sampled, aligned with stage [1] of sclk
  logic [1:0] sdio_q;

  // Synchronizer and history shift registers.
  // cs resets to "selected" so a frame already under way at reset release
  // produces no falling edge and is ignored until CS goes high.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= '0;
      sclk_q <= '0;
      sdio_q <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], spi_cs_n};
      sclk_q <= {sclk_q[1:0], spi_sclk};
      sdio_q <= {sdio_q[0], sdio_in};
    end
  end

  // Edge decode between the synchronized value and its history.
  always_comb begin
    sclk_rise = sclk_q[1] & ~sclk_q[2];
    sclk_fall = ~sclk_q[1] & sclk_q[2];
    cs_rise   = cs_q[1] & ~cs_q[2];
    cs_fall   = ~cs_q[1] & cs_q[2];
    sdio_s    = sdio_q[1];
  end

endmodule

// File: rtl/spi3w_cfg_responder.sv
// 3-wire SPI responder emulating a converter configuration port.
module spi3w_cfg_responder
  import spi3w_pkg::*;
#(
  parameter bit          ADDR_2BYTE  = 1'b1,
  parameter int unsigned NUM_REGS    = 64,
  parameter int unsigned STATUS_ADDR = 'h1F,
  parameter int unsigned MIN_HALF    = 4
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic                  spi_cs_n,
  input  logic                  spi_sclk,
  input  logic                  sdio_in,
  output logic                  sdio_out,
  output logic                  sdio_oe,
  input  logic [7:0]            status_in,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned IL    = ADDR_2BYTE ? IL_2BYTE : IL_1BYTE;
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  // MIN_HALF only constrains the master timing; the logic does not depend on it.
  logic unused_min_half;
  assign unused_min_half = (MIN_HALF > 0);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, sdio_s;

  spi3w_pin_sync u_pin_sync (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .sdio_in   (sdio_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .sdio_s    (sdio_s)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [14:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          tx_q, tx_d;
  logic                oe_q, oe_d;
  logic                out_q, out_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                frame_err_q, frame_err_d;
  logic [7:0]          regs_q [NUM_REGS];

  logic [15:0]         shift_in;
  logic [CNT_W-1:0]    cnt_inc;
  logic [ADDR_W-1:0]   instr_addr_w;
  logic                instr_rw;
  logic [7:0]          rd_byte;
  logic                writable;

  // Shift path, decoded instruction fields and write permission.
  always_comb begin
    shift_in     = {shift_q, sdio_s};
    cnt_inc      = cnt_q + 1'b1;
    instr_addr_w = instr_addr(shift_in, ADDR_2BYTE);
    instr_rw     = ADDR_2BYTE ? shift_in[RW_BIT_2BYTE] : shift_in[RW_BIT_1BYTE];
    writable     = (32'(addr_q) < NUM_REGS) && (addr_q != ADDR_W'(STATUS_ADDR));
  end

  // Read byte for the address being decoded, loaded into TX on RDATA entry.
  always_comb begin
    rd_byte = regs_q[instr_addr_w[IDX_W-1:0]];
    if (instr_addr_w == ADDR_W'(STATUS_ADDR)) begin
      rd_byte = status_in;
    end else if (32'(instr_addr_w) >= NUM_REGS) begin
      rd_byte = 8'h00;
    end
  end

  // Frame FSM next state. CS edges take priority over SCLK edges.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    oe_d        = oe_q;
    out_d       = out_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;

    if (cs_rise) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      if (state_q == StInstr || state_q == StWdata || state_q == StRdata) begin
        frame_err_d = 1'b1;
      end
    end else if (cs_fall) begin
      if (state_q == StIdle) begin
        state_d = StInstr;
        cnt_d   = '0;
        shift_d = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StInstr: begin
          if (sclk_rise) begin
            shift_d = shift_in[14:0];
            cnt_d   = cnt_inc;
            if (cnt_inc == CNT_W'(IL)) begin
              cnt_d  = '0;
              addr_d = instr_addr_w;
              if (instr_rw) begin
                state_d = StRdata;
                tx_d    = rd_byte;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StWdata: begin
          if (sclk_rise) begin
            shift_d = shift_in[14:0];
            cnt_d   = cnt_inc;
            if (cnt_inc == CNT_W'(8)) begin
              state_d = StDone;
              if (writable) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = shift_in[7:0];
              end
            end
          end
        end
        StRdata: begin
          if (sclk_fall) begin
            oe_d  = 1'b1;
            out_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end
          if (sclk_rise) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(8)) begin
              state_d = StDone;
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register file, cleared by reset, written when a write frame commits.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (wr_stb_d) begin
      regs_q[wr_addr_d[IDX_W-1:0]] <= wr_data_d;
    end
  end

  // Pad release happens in the same cycle as the synchronized CS rise.
  always_comb begin
    sdio_oe   = oe_q & ~cs_rise;
    sdio_out  = out_q;
    wr_stb    = wr_stb_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    frame_err = frame_err_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_spi3w_cfg_responder.sv
// Self-checking bench: one 16-bit-instruction and one 8-bit-instruction responder.
module tb_spi3w_cfg_responder;

  localparam int H = 8;  // SCLK half-period in clk_50m cycles

  logic        clk_50m = 1'b0;
  logic        rst_n   = 1'b0;
  logic [7:0]  status_in = 8'h00;
  logic        cs_n    [2];
  logic        sclk    [2];
  logic        sdio_in [2];
  logic        sdio_out[2];
  logic        sdio_oe [2];
  logic        wr_stb  [2];
  logic        frame_err[2];
  logic        busy    [2];
  logic [12:0] wr_addr [2];
  logic [7:0]  wr_data [2];

  int n_vec = 0;
  int n_err = 0;

  // Monitor results
  int          stb_cnt [2] = '{0, 0};
  int          ferr_cnt[2] = '{0, 0};
  int          both_cnt    = 0;
  logic [12:0] last_addr[2];
  logic [7:0]  last_data[2];
  logic        busy_mid;

  // Reference register images (index 0: 16-bit mode, 1: 8-bit mode)
  logic [7:0]  mdl [2][64];

  always #10 clk_50m = ~clk_50m;

  spi3w_cfg_responder #(
    .ADDR_2BYTE (1'b1), .NUM_REGS (64), .STATUS_ADDR ('h1F), .MIN_HALF (4)
  ) u_dut16 (
    .clk_50m (clk_50m), .rst_n (rst_n), .spi_cs_n (cs_n[0]), .spi_sclk (sclk[0]),
    .sdio_in (sdio_in[0]), .sdio_out (sdio_out[0]), .sdio_oe (sdio_oe[0]),
    .status_in (status_in), .wr_stb (wr_stb[0]), .wr_addr (wr_addr[0]),
    .wr_data (wr_data[0]), .frame_err (frame_err[0]), .busy (busy[0])
  );

  spi3w_cfg_responder #(
    .ADDR_2BYTE (1'b0), .NUM_REGS (64), .STATUS_ADDR ('h1F), .MIN_HALF (4)
  ) u_dut8 (
    .clk_50m (clk_50m), .rst_n (rst_n), .spi_cs_n (cs_n[1]), .spi_sclk (sclk[1]),
    .sdio_in (sdio_in[1]), .sdio_out (sdio_out[1]), .sdio_oe (sdio_oe[1]),
    .status_in (status_in), .wr_stb (wr_stb[1]), .wr_addr (wr_addr[1]),
    .wr_data (wr_data[1]), .frame_err (frame_err[1]), .busy (busy[1])
  );

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk_50m) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_stb[d] === 1'b1) begin
        stb_cnt[d]++;
        last_addr[d] = wr_addr[d];
        last_data[d] = wr_data[d];
      end
      if (frame_err[d] === 1'b1) ferr_cnt[d]++;
      if (wr_stb[d] === 1'b1 && frame_err[d] === 1'b1) both_cnt++;
    end
  end

  function automatic logic [7:0] exp_read(input int d, input int addr);
    if (addr == 'h1F) return status_in;
    if (addr >= 64) return 8'h00;
    return mdl[d][addr];
  endfunction

  function automatic bit exp_writes(input int addr);
    return (addr < 64) && (addr != 'h1F);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic cs_low(input int d);
    cs_n[d] = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high(input int d);
    wait_clk(H);
    cs_n[d] = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic bit_out(input int d, input logic b);
    sdio_in[d] = b;
    wait_clk(H);
    sclk[d] = 1'b1;
    wait_clk(H);
    sclk[d] = 1'b0;
  endtask

  // Master samples the responder just before raising SCLK
  task automatic bit_in(input int d, output logic b, output logic oe);
    wait_clk(H);
    b  = sdio_out[d];
    oe = sdio_oe[d];
    sclk[d] = 1'b1;
    wait_clk(H);
    sclk[d] = 1'b0;
  endtask

  task automatic send_instr(input int d, input logic rw, input int addr);
    logic [15:0] ins;
    int il;
    if (d == 0) begin
      ins = {rw, 2'b00, 13'(addr)};
      il  = 16;
    end else begin
      ins = {8'h00, rw, 7'(addr)};
      il  = 8;
    end
    for (int i = il - 1; i >= 0; i--) bit_out(d, ins[i]);
  endtask

  // nbits data bits are clocked; beyond 8 the extra bits are ones
  task automatic write_frame(input int d, input int addr, input logic [7:0] data,
                             input int nbits);
    cs_low(d);
    busy_mid = busy[d];
    send_instr(d, 1'b0, addr);
    for (int i = 0; i < nbits; i++) bit_out(d, (i < 8) ? data[7-i] : 1'b1);
    cs_high(d);
  endtask

  task automatic read_frame(input int d, input int addr, output logic [7:0] rd,
                            output logic oe_all, output logic oe_after);
    logic b, oe;
    oe_all = 1'b1;
    cs_low(d);
    send_instr(d, 1'b1, addr);
    for (int i = 0; i < 8; i++) begin
      bit_in(d, b, oe);
      rd[7-i] = b;
      oe_all  = oe_all & oe;
    end
    wait_clk(H);
    oe_all   = oe_all & sdio_oe[d];
    cs_n[d]  = 1'b1;
    wait_clk(4);
    oe_after = sdio_oe[d];
    wait_clk(2 * H);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      cs_n[d] = 1'b1; sclk[d] = 1'b0; sdio_in[d] = 1'b0;
      for (int a = 0; a < 64; a++) mdl[d][a] = 8'h00;
    end
    rst_n = 1'b0;
    wait_clk(3);
    for (int d = 0; d < 2; d++) begin
      n_vec += 7;
      if (sdio_oe[d] !== 1'b0) begin n_err++; $display("FAIL reset_oe dut%0d got %b want 0", d, sdio_oe[d]); end
      if (sdio_out[d] !== 1'b0) begin n_err++; $display("FAIL reset_out dut%0d got %b want 0", d, sdio_out[d]); end
      if (wr_stb[d] !== 1'b0) begin n_err++; $display("FAIL reset_stb dut%0d got %b want 0", d, wr_stb[d]); end
      if (wr_addr[d] !== 13'h0) begin n_err++; $display("FAIL reset_addr dut%0d got %h want 0", d, wr_addr[d]); end
      if (wr_data[d] !== 8'h0) begin n_err++; $display("FAIL reset_data dut%0d got %h want 0", d, wr_data[d]); end
      if (frame_err[d] !== 1'b0) begin n_err++; $display("FAIL reset_ferr dut%0d got %b want 0", d, frame_err[d]); end
      if (busy[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d got %b want 0", d, busy[d]); end
    end
    rst_n = 1'b1;
    wait_clk(10);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (busy[d] !== 1'b0) begin n_err++; $display("FAIL post_reset_busy dut%0d got %b want 0", d, busy[d]); end
    end
  endtask

  task automatic test_write_read16;
    int s0;
    logic [7:0] rd;
    logic oe_all, oe_after;
    s0 = stb_cnt[0];
    write_frame(0, 'h010, 8'hA5, 8);
    mdl[0]['h10] = 8'hA5;
    n_vec += 4;
    if (busy_mid !== 1'b1) begin n_err++; $display("FAIL wr16_busy got %b want 1", busy_mid); end
    if (stb_cnt[0] - s0 != 1) begin n_err++; $display("FAIL wr16_stb_count got %0d want 1", stb_cnt[0] - s0); end
    if (last_addr[0] !== 13'h010) begin n_err++; $display("FAIL wr16_addr got %h want 010", last_addr[0]); end
    if (last_data[0] !== 8'hA5) begin n_err++; $display("FAIL wr16_data got %h want a5", last_data[0]); end
    read_frame(0, 'h010, rd, oe_all, oe_after);
    n_vec += 3;
    if (rd !== 8'hA5) begin n_err++; $display("FAIL rd16_data got %h want a5", rd); end
    if (oe_all !== 1'b1) begin n_err++; $display("FAIL rd16_oe_during got %b want 1", oe_all); end
    if (oe_after !== 1'b0) begin n_err++; $display("FAIL rd16_oe_after_cs got %b want 0", oe_after); end
  endtask

  task automatic test_status;
    int s0;
    logic [7:0] rd;
    logic oe_all, oe_after;
    status_in = 8'h3C;
    read_frame(0, 'h1F, rd, oe_all, oe_after);
    n_vec++;
    if (rd !== 8'h3C) begin n_err++; $display("FAIL status_rd got %b want 00111100", rd); end
    s0 = stb_cnt[0];
    write_frame(0, 'h1F, 8'hFF, 8);
    n_vec++;
    if (stb_cnt[0] != s0) begin n_err++; $display("FAIL status_wr_stb got %0d want 0", stb_cnt[0] - s0); end
    read_frame(0, 'h1F, rd, oe_all, oe_after);
    n_vec++;
    if (rd !== 8'h3C) begin n_err++; $display("FAIL status_rd_after_wr got %h want 3c", rd); end
  endtask

  task automatic test_mode8;
    int s0;
    logic [7:0] rd;
    logic oe_all, oe_after;
    s0 = stb_cnt[1];
    write_frame(1, 'h05, 8'h5A, 8);
    mdl[1][5] = 8'h5A;
    n_vec += 3;
    if (stb_cnt[1] - s0 != 1) begin n_err++; $display("FAIL m8_stb_count got %0d want 1", stb_cnt[1] - s0); end
    if (last_addr[1] !== 13'h005) begin n_err++; $display("FAIL m8_addr got %h want 005", last_addr[1]); end
    if (last_data[1] !== 8'h5A) begin n_err++; $display("FAIL m8_data got %h want 5a", last_data[1]); end
    read_frame(1, 'h05, rd, oe_all, oe_after);
    n_vec++;
    if (rd !== 8'h5A) begin n_err++; $display("FAIL m8_rd got %h want 5a", rd); end
    read_frame(1, 'h50, rd, oe_all, oe_after);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL m8_rd_oob got %h want 00", rd); end
  endtask

  task automatic test_truncated;
    int s0, f0;
    logic [7:0] v, v2, rd;
    logic oe_all, oe_after;
    v  = 8'($urandom);
    v2 = 8'($urandom);
    write_frame(0, 'h003, v, 8);
    mdl[0][3] = v;
    s0 = stb_cnt[0];
    f0 = ferr_cnt[0];
    write_frame(0, 'h003, ~v, 4);
    n_vec += 2;
    if (ferr_cnt[0] - f0 != 1) begin n_err++; $display("FAIL trunc_ferr got %0d want 1", ferr_cnt[0] - f0); end
    if (stb_cnt[0] != s0) begin n_err++; $display("FAIL trunc_stb got %0d want 0", stb_cnt[0] - s0); end
    read_frame(0, 'h003, rd, oe_all, oe_after);
    n_vec++;
    if (rd !== v) begin n_err++; $display("FAIL trunc_reg got %h want %h", rd, v); end
    write_frame(0, 'h003, v2, 8);
    mdl[0][3] = v2;
    read_frame(0, 'h003, rd, oe_all, oe_after);
    n_vec += 3;
    if (stb_cnt[0] - s0 != 1) begin n_err++; $display("FAIL trunc_next_stb got %0d want 1", stb_cnt[0] - s0); end
    if (ferr_cnt[0] - f0 != 1) begin n_err++; $display("FAIL trunc_next_ferr got %0d want 1", ferr_cnt[0] - f0); end
    if (rd !== v2) begin n_err++; $display("FAIL trunc_next_reg got %h want %h", rd, v2); end
  endtask

  task automatic test_extra_sclk;
    int s0, f0;
    logic [7:0] rd;
    logic oe_all, oe_after;
    s0 = stb_cnt[0];
    f0 = ferr_cnt[0];
    write_frame(0, 'h010, 8'h11, 16);
    mdl[0]['h10] = 8'h11;
    read_frame(0, 'h010, rd, oe_all, oe_after);
    n_vec += 3;
    if (stb_cnt[0] - s0 != 1) begin n_err++; $display("FAIL extra_stb got %0d want 1", stb_cnt[0] - s0); end
    if (ferr_cnt[0] != f0) begin n_err++; $display("FAIL extra_ferr got %0d want 0", ferr_cnt[0] - f0); end
    if (rd !== 8'h11) begin n_err++; $display("FAIL extra_reg got %h want 11", rd); end
  endtask

  task automatic test_random;
    int d, addr, sel, s0;
    logic rw;
    logic [7:0] data, rd, exp;
    logic oe_all, oe_after;
    for (int it = 0; it < 40; it++) begin
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      rw  = 1'($urandom);
      data = 8'($urandom);
      status_in = 8'($urandom);
      case (sel)
        0:       addr = int'($urandom_range(0, 63));
        1:       addr = 'h1F;
        2:       addr = (d == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 127));
        default: addr = int'($urandom_range(64, 127));
      endcase
      if (rw) begin
        exp = exp_read(d, addr);
        read_frame(d, addr, rd, oe_all, oe_after);
        n_vec++;
        if (rd !== exp) begin n_err++; $display("FAIL rnd_rd dut%0d addr %h got %h want %h", d, addr, rd, exp); end
      end else begin
        s0 = stb_cnt[d];
        write_frame(d, addr, data, 8);
        n_vec++;
        if (exp_writes(addr)) begin
          mdl[d][addr] = data;
          if (stb_cnt[d] - s0 != 1 || last_addr[d] !== 13'(addr) || last_data[d] !== data) begin
            n_err++;
            $display("FAIL rnd_wr dut%0d stb %0d addr %h data %h want 1 %h %h", d,
                     stb_cnt[d] - s0, last_addr[d], last_data[d], addr, data);
          end
        end else if (stb_cnt[d] != s0) begin
          n_err++;
          $display("FAIL rnd_wr_blocked dut%0d addr %h got %0d strobes want 0", d, addr, stb_cnt[d] - s0);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int s0, f0;
    logic b, oe, oe_all, oe_after;
    logic [7:0] rd;
    cs_low(0);
    send_instr(0, 1'b1, 'h010);
    bit_in(0, b, oe);
    bit_in(0, b, oe);
    n_vec++;
    if (sdio_oe[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_oe_before got %b want 1", sdio_oe[0]); end
    rst_n = 1'b0;
    #1;
    n_vec += 2;
    if (sdio_oe[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_oe got %b want 0", sdio_oe[0]); end
    if (busy[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy[0]); end
    for (int d = 0; d < 2; d++) for (int a = 0; a < 64; a++) mdl[d][a] = 8'h00;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    s0 = stb_cnt[0];
    f0 = ferr_cnt[0];
    // CS is still low from before the reset: this frame must be ignored
    send_instr(0, 1'b0, 'h005);
    for (int i = 0; i < 8; i++) bit_out(0, 1'b1);
    cs_high(0);
    n_vec += 2;
    if (stb_cnt[0] != s0) begin n_err++; $display("FAIL rstmid_stale_stb got %0d want 0", stb_cnt[0] - s0); end
    if (ferr_cnt[0] != f0) begin n_err++; $display("FAIL rstmid_stale_ferr got %0d want 0", ferr_cnt[0] - f0); end
    read_frame(0, 'h010, rd, oe_all, oe_after);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL rstmid_reg010 got %h want 00", rd); end
    read_frame(0, 'h005, rd, oe_all, oe_after);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL rstmid_reg005 got %h want 00", rd); end
    read_frame(1, 'h05, rd, oe_all, oe_after);
    n_vec++;
    if (rd !== 8'h00) begin n_err++; $display("FAIL rstmid_m8_reg05 got %h want 00", rd); end
  endtask

  task automatic test_exclusive;
    n_vec++;
    if (both_cnt != 0) begin n_err++; $display("FAIL stb_ferr_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read16();
    test_status();
    test_mode8();
    test_truncated();
    test_extra_sclk();
    test_random();
    test_reset_mid();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
